// File: rtl/bram_arbiter_if.sv
// Requester-side bus of the BRAM arbiter.
// All NREQ requesters share one bundle: each lane has a slice of every field.
//   req   : per-requester access request
//   rw    : per-requester direction (1=read, 0=write)
//   mode  : per-requester access mode, lane i at [2i+1:2i]
//   addr  : per-requester address, lane i at [AW*i +: AW]
//   wdata : per-requester write data, lane i at [DW*i +: DW]
//   ack   : one-hot, one-cycle completion pulse from the arbiter
//   rdata : read data, valid while ack is high
// master = requester side, slave = arbiter side.
interface bram_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 40,
    parameter int DW   = 40
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    rw;
    logic [2*NREQ-1:0]  mode;
    logic [AW*NREQ-1:0] addr;
    logic [DW*NREQ-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;

    modport master (output req, rw, mode, addr, wdata, input ack, rdata);
    modport slave  (input req, rw, mode, addr, wdata, output ack, rdata);
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one bramctl port between NREQ requesters.
// Each access is latched, held through bramctl's fixed latency LAT, and
// completed with a one-cycle ack pulse to the winner. The arbiter also owns
// bramctl's arraywidth and only changes it while no access is in flight.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   rq              : requester bus (bram_arbiter_if.slave)
//   busy            : high whenever an access is in progress
//   cfg_we/cfg_arraywidth : arraywidth update request
//   arraywidth      : to bramctl
//   MemAddr/MemDataIn/mem_mode/RW : registered request to bramctl
//   MemDataOut      : read data from bramctl
module bram_arbiter #(
    parameter int NREQ   = 3,
    parameter int AW     = 40,
    parameter int DW     = 40,
    parameter int LAT    = 1,
    parameter int AW_RST = 64
) (
    input  logic          clk,
    input  logic          rst,
    bram_arbiter_if.slave rq,
    output logic          busy,
    input  logic          cfg_we,
    input  logic [15:0]   cfg_arraywidth,
    output logic [15:0]   arraywidth,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemDataIn,
    input  logic [DW-1:0] MemDataOut,
    output logic [1:0]    mem_mode,
    output logic          RW
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    logic [1:0]      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt;
    logic [PW-1:0]   win;
    logic            found;
    logic [CW-1:0]   cnt;
    logic            pend;
    logic [15:0]     pend_val;
    logic [NREQ-1:0] ack_q;
    logic [DW-1:0]   rdata_q;

    assign rq.ack   = ack_q;
    assign rq.rdata = rdata_q;
    assign busy     = (state != IDLE);

    // Circular priority scan: the first set req at or after ptr wins.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && rq.req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt        <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            pend_val   <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            arraywidth <= 16'(AW_RST);
            MemAddr    <= '0;
            MemDataIn  <= '0;
            mem_mode   <= '0;
            RW         <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        MemAddr   <= rq.addr[AW*win +: AW];
                        MemDataIn <= rq.wdata[DW*win +: DW];
                        mem_mode  <= rq.mode[2*win +: 2];
                        RW        <= rq.rw[win];
                        gnt       <= win;
                        ptr       <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                        cnt       <= CW'(LAT);
                        state     <= WAIT;
                        // A grant on this edge makes the access in flight,
                        // so the new width must wait for it to finish.
                        if (cfg_we) begin
                            pend     <= 1'b1;
                            pend_val <= cfg_arraywidth;
                        end
                    end else if (cfg_we) begin
                        arraywidth <= cfg_arraywidth;
                    end
                end
                WAIT: begin
                    if (cfg_we) begin
                        pend     <= 1'b1;
                        pend_val <= cfg_arraywidth;
                    end
                    if (cnt == '0) begin
                        if (RW) rdata_q <= MemDataOut;
                        ack_q[gnt] <= 1'b1;
                        RW         <= 1'b1;
                        state      <= ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    // Requests are ignored here; a req still high is seen
                    // as a fresh request on the next IDLE edge.
                    ack_q <= '0;
                    state <= IDLE;
                    pend  <= 1'b0;
                    if (cfg_we)    arraywidth <= cfg_arraywidth;
                    else if (pend) arraywidth <= pend_val;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
module tb_bram_arbiter;
    localparam int NREQ   = 3;
    localparam int AW     = 40;
    localparam int DW     = 40;
    localparam int LAT    = 1;
    localparam int AW_RST = 64;
    localparam logic [1:0] WORD = 2'b10;
    localparam logic [1:0] NEIG = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic          cfg_we;
    logic [15:0]   cfg_arraywidth;
    logic [15:0]   arraywidth;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemDataIn;
    logic [DW-1:0] MemDataOut;
    logic [1:0]    mem_mode;
    logic          RW;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    bram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LAT(LAT), .AW_RST(AW_RST)) dut (
        .clk(clk), .rst(rst), .rq(bus), .busy(busy),
        .cfg_we(cfg_we), .cfg_arraywidth(cfg_arraywidth), .arraywidth(arraywidth),
        .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut),
        .mem_mode(mem_mode), .RW(RW)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] seed(input int i);
        case (i)
            3:       return 40'h0123456789;
            5:       return 40'hdeadbeef23;
            9:       return 40'h9999999999;
            default: return 40'h5a00000000 | 40'(i);
        endcase
    endfunction

    // bramctl stand-in: one-cycle registered read, write while RW==0.
    logic seeded = 1'b0;
    logic [DW-1:0] bmem [256];
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 256; i++) bmem[i] <= seed(i);
            MemDataOut <= '0;
        end else begin
            if (!RW) bmem[MemAddr[7:0]] <= MemDataIn;
            MemDataOut <= bmem[MemAddr[7:0]];
        end
    end

    // Reference model: an access occupies LAT+3 edges counted from its grant;
    // data and ack appear LAT+1 edges after the grant, release at LAT+2.
    logic [DW-1:0]   gold [256];
    logic            m_live = 1'b0;
    logic            m_busy, n_busy;
    int              m_age, n_age, m_w, n_w, m_ptr, n_ptr, cand;
    logic            m_pend, n_pend;
    logic [15:0]     m_pval, n_pval, exp_aw, n_aw;
    logic [NREQ-1:0] exp_ack, n_ack;
    logic [DW-1:0]   exp_rdata, n_rdata, exp_din, n_din;
    logic [AW-1:0]   exp_addr, n_addr;
    logic [1:0]      exp_mode, n_mode;
    logic            exp_rw, n_rw, g_we;

    function automatic int first_from(input int p, input logic [NREQ-1:0] r);
        int res = -1;
        for (int k = 0; k < NREQ; k++)
            if (res < 0 && r[(p + k) % NREQ]) res = (p + k) % NREQ;
        return res;
    endfunction

    always_comb begin
        n_busy = m_busy; n_age = m_age + 1; n_w = m_w; n_ptr = m_ptr;
        n_pend = m_pend; n_pval = m_pval; n_aw = exp_aw;
        n_ack = exp_ack; n_rdata = exp_rdata; n_addr = exp_addr;
        n_din = exp_din; n_mode = exp_mode; n_rw = exp_rw; g_we = 1'b0;
        cand = first_from(m_ptr, bus.req);
        if (m_busy) begin
            if (m_age + 1 == LAT + 1) begin
                if (exp_rw) n_rdata = gold[exp_addr[7:0]];
                n_ack = NREQ'(1) << m_w;
                n_rw  = 1'b1;
            end
            if (m_age + 1 == LAT + 2) begin
                n_ack  = '0;
                n_busy = 1'b0;
                n_pend = 1'b0;
                n_aw   = cfg_we ? cfg_arraywidth : (m_pend ? m_pval : exp_aw);
            end else if (cfg_we) begin
                n_pend = 1'b1;
                n_pval = cfg_arraywidth;
            end
        end else if (cand >= 0) begin
            n_busy = 1'b1; n_age = 0; n_w = cand; n_ptr = (cand + 1) % NREQ;
            n_addr = bus.addr[AW*cand +: AW];
            n_din  = bus.wdata[DW*cand +: DW];
            n_mode = bus.mode[2*cand +: 2];
            n_rw   = bus.rw[cand];
            g_we   = !bus.rw[cand];
            if (cfg_we) begin
                n_pend = 1'b1;
                n_pval = cfg_arraywidth;
            end
        end else if (cfg_we) begin
            n_aw = cfg_arraywidth;
        end
    end

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 256; i++) gold[i] <= seed(i);
            seeded <= 1'b1;
        end
        if (!rst) begin
            m_live <= 1'b1; m_busy <= 1'b0; m_age <= 0; m_w <= 0; m_ptr <= 0;
            m_pend <= 1'b0; m_pval <= '0; exp_aw <= 16'(AW_RST);
            exp_ack <= '0; exp_rdata <= '0; exp_addr <= '0; exp_din <= '0;
            exp_mode <= '0; exp_rw <= 1'b1;
        end else if (m_live) begin
            m_busy <= n_busy; m_age <= n_age; m_w <= n_w; m_ptr <= n_ptr;
            m_pend <= n_pend; m_pval <= n_pval; exp_aw <= n_aw;
            exp_ack <= n_ack; exp_rdata <= n_rdata; exp_addr <= n_addr;
            exp_din <= n_din; exp_mode <= n_mode; exp_rw <= n_rw;
            if (g_we) gold[n_addr[7:0]] <= n_din;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("ack",        64'(bus.ack),    64'(exp_ack));
            chk("rdata",      64'(bus.rdata),  64'(exp_rdata));
            chk("busy",       64'(busy),       64'(m_busy));
            chk("MemAddr",    64'(MemAddr),    64'(exp_addr));
            chk("MemDataIn",  64'(MemDataIn),  64'(exp_din));
            chk("mem_mode",   64'(mem_mode),   64'(exp_mode));
            chk("RW",         64'(RW),         64'(exp_rw));
            chk("arraywidth", 64'(arraywidth), 64'(exp_aw));
        end
    end

    int ack_who[$];
    int ack_cyc[$];
    always @(negedge clk)
        for (int k = 0; k < NREQ; k++)
            if (bus.ack[k]) begin
                ack_who.push_back(k);
                ack_cyc.push_back(cyc);
            end

    task automatic drive(input int i, input logic r, input logic [1:0] m,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.rw[i] = r;
        bus.mode[2*i +: 2] = m;
        bus.addr[AW*i +: AW] = a;
        bus.wdata[DW*i +: DW] = d;
        bus.req[i] = 1'b1;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        chk("grant_wait", 64'(busy), 64'd1);
    endtask

    task automatic wait_ack(input int i);
        int n = 0;
        while (!bus.ack[i] && n < 20) begin @(negedge clk); n++; end
        chk("ack_wait", 64'(bus.ack[i]), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    int exp_ord [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        int base, n0, n;
        rst = 1'b0; cfg_we = 1'b0; cfg_arraywidth = '0;
        bus.req = '0; bus.rw = '0; bus.mode = '0; bus.addr = '0; bus.wdata = '0;

        // Reset state and single read.
        repeat (2) @(negedge clk);
        chk("rst_RW", 64'(RW), 64'd1);
        chk("rst_MemAddr", 64'(MemAddr), 64'd0);
        chk("rst_aw", 64'(arraywidth), 64'd64);
        chk("rst_ack", 64'(bus.ack), 64'd0);
        rst = 1'b1;
        drive(0, 1'b1, WORD, 40'd5, '0);
        @(negedge clk);
        chk("rd_MemAddr", 64'(MemAddr), 64'd5);
        bus.req[0] = 1'b0;
        @(negedge clk);
        chk("rd_ack_early", 64'(bus.ack), 64'd0);
        @(negedge clk);
        chk("rd_ack", 64'(bus.ack), 64'b001);
        chk("rd_data", 64'(bus.rdata), 64'h00deadbeef23);
        @(negedge clk);

        // Write then read back.
        drive(1, 1'b0, WORD, 40'd8, 40'hfeedface45);
        wait_busy();
        chk("wr_RW", 64'(RW), 64'd0);
        bus.req[1] = 1'b0;
        wait_ack(1);
        chk("wr_rdata_kept", 64'(bus.rdata), 64'h00deadbeef23);
        @(negedge clk);
        drive(1, 1'b1, WORD, 40'd8, '0);
        wait_busy();
        bus.req[1] = 1'b0;
        wait_ack(1);
        chk("rb_data", 64'(bus.rdata), 64'h00feedface45);
        @(negedge clk);

        // Round-robin with all requesters held from reset.
        do_reset();
        base = ack_who.size();
        drive(0, 1'b1, WORD, 40'd1, '0);
        drive(1, 1'b1, WORD, 40'd2, '0);
        drive(2, 1'b1, WORD, 40'd3, '0);
        n = 0;
        while (ack_who.size() < base + 6 && n < 80) begin @(negedge clk); n++; end
        bus.req = '0;
        chk("rr_count", 64'(ack_who.size() - base), 64'd6);
        if (ack_who.size() >= base + 6) begin
            for (int j = 0; j < 6; j++) chk("rr_order", 64'(ack_who[base+j]), 64'(exp_ord[j]));
            for (int j = 1; j < 6; j++)
                chk("rr_gap_ge3", 64'(ack_cyc[base+j] - ack_cyc[base+j-1] >= 3), 64'd1);
        end
        @(negedge clk);

        // Deferred configuration during a NEIG read.
        drive(2, 1'b1, NEIG, 40'd87, '0);
        wait_busy();
        bus.req[2] = 1'b0;
        cfg_we = 1'b1; cfg_arraywidth = 16'd6;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_hold_wait", 64'(arraywidth), 64'd64);
        wait_ack(2);
        chk("cfg_hold_ack", 64'(arraywidth), 64'd64);
        @(negedge clk);
        chk("cfg_applied", 64'(arraywidth), 64'd6);
        cfg_we = 1'b1; cfg_arraywidth = 16'd9;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_idle", 64'(arraywidth), 64'd9);

        // Reset mid-access.
        drive(1, 1'b1, WORD, 40'd5, '0);
        wait_busy();
        bus.req[1] = 1'b0;
        n0 = ack_who.size();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ack", 64'(bus.ack), 64'd0);
        chk("mid_MemAddr", 64'(MemAddr), 64'd0);
        chk("mid_RW", 64'(RW), 64'd1);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_aw", 64'(arraywidth), 64'd64);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_no_ack", 64'(ack_who.size()), 64'(n0));
        // Pointer back at 0: requester 1 must beat requester 2.
        drive(1, 1'b1, WORD, 40'd4, '0);
        drive(2, 1'b1, WORD, 40'd6, '0);
        wait_busy();
        bus.req = '0;
        wait_ack(1);
        @(negedge clk);

        // Request fields change after grant.
        drive(0, 1'b1, WORD, 40'd3, '0);
        wait_busy();
        bus.req[0] = 1'b0;
        bus.addr[AW*0 +: AW] = 40'd9;
        @(negedge clk);
        chk("hold_MemAddr_wait", 64'(MemAddr), 64'd3);
        wait_ack(0);
        chk("hold_MemAddr_ack", 64'(MemAddr), 64'd3);
        chk("hold_rdata", 64'(bus.rdata), 64'h000123456789);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
